// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared widths, in-flight queue entry layout and training FSM states
// for the perceptron branch-predictor training controller.
package global_parameters;

  localparam int Y_OUT_WIDTH = 12;
  localparam int HIST_LEN    = 12;
  localparam int IDX_WIDTH   = 7;
  localparam int THETA       = 37;
  localparam int WIDX_WIDTH  = $clog2(HIST_LEN + 1);

  typedef struct packed {
    logic [IDX_WIDTH-1:0]          idx;
    logic signed [Y_OUT_WIDTH-1:0] y;
    logic                          pred_bit;
    logic [HIST_LEN-1:0]           ghr;
  } inflight_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRAIN = 1'b1
  } train_state_t;

endpackage

// File: rtl/perceptron_train_ctrl_inflight_fifo.sv
// In-order queue of predictions awaiting resolution. Push is refused when
// full, pop when empty, and flush drops everything and wins over both.
module inflight_fifo
  import global_parameters::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  inflight_entry_t wr_entry,
  output inflight_entry_t rd_entry,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);

  inflight_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign rd_entry = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: records predictions, judges each
// resolution against the threshold and streams one +/-1 update per weight.
module perceptron_train_ctrl
  import global_parameters::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pred_valid,
  output logic                          pred_ready,
  input  logic [IDX_WIDTH-1:0]          pred_idx,
  input  logic signed [Y_OUT_WIDTH-1:0] pred_y,
  input  logic [HIST_LEN-1:0]           pred_ghr,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic                          res_taken,
  input  logic                          flush,
  output logic                          upd_valid,
  input  logic                          upd_ready,
  output logic [IDX_WIDTH-1:0]          upd_idx,
  output logic [WIDX_WIDTH-1:0]         upd_widx,
  output logic                          upd_inc,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          mispredict_cnt,
  output logic [CNT_WIDTH-1:0]          train_cnt
);

  // Magnitude of y one bit wider, so the most negative value stays positive.
  function automatic logic [Y_OUT_WIDTH:0] abs_y(input logic signed [Y_OUT_WIDTH-1:0] v);
    logic signed [Y_OUT_WIDTH:0] ext;
    ext = {v[Y_OUT_WIDTH-1], v};
    return ext[Y_OUT_WIDTH] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  train_state_t          state_q, state_d;
  logic [WIDX_WIDTH-1:0] widx_q, widx_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [HIST_LEN-1:0]   ghr_q, ghr_d;
  logic                  taken_q, taken_d;
  inflight_entry_t       push_entry;
  inflight_entry_t       head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  res_fire;
  logic                  mis;
  logic                  trn;
  logic [Y_OUT_WIDTH:0]  absy;
  logic [HIST_LEN:0]     weight_vec;

  assign push_entry = '{idx: pred_idx, y: pred_y, pred_bit: ~pred_y[Y_OUT_WIDTH-1], ghr: pred_ghr};

  inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pred_valid && pred_ready),
    .pop      (res_fire),
    .flush    (flush),
    .wr_entry (push_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pred_ready = !fifo_full;
  assign res_ready  = (state_q == IDLE) && !fifo_empty && !flush;
  assign res_fire   = res_valid && res_ready;
  assign mis        = (head.pred_bit != res_taken);
  assign absy       = abs_y(head.y);
  assign trn        = mis || (absy <= (Y_OUT_WIDTH + 1)'(THETA));

  // Bit 0 stands for the bias input; bit k pairs weight k with ghr[k-1].
  assign weight_vec = {ghr_q, taken_q};
  assign busy       = (state_q == TRAIN);
  assign upd_valid  = busy;
  assign upd_idx    = idx_q;
  assign upd_widx   = widx_q;
  assign upd_inc    = busy && ((widx_q == '0) ? taken_q : (taken_q == weight_vec[widx_q]));

  // Training state, episode context and weight pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      widx_q  <= '0;
      idx_q   <= '0;
      ghr_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      idx_q   <= idx_d;
      ghr_q   <= ghr_d;
      taken_q <= taken_d;
    end
  end

  // Next state: start an episode on a resolution needing training, step the
  // weight pointer on each accepted update, and drop back to IDLE on flush.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    idx_d   = idx_q;
    ghr_d   = ghr_q;
    taken_d = taken_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (res_fire && trn) begin
            state_d = TRAIN;
            widx_d  = '0;
            idx_d   = head.idx;
            ghr_d   = head.ghr;
            taken_d = res_taken;
          end
        end
        TRAIN: begin
          if (upd_ready) begin
            if (widx_q == WIDX_WIDTH'(HIST_LEN)) state_d = IDLE;
            else                                 widx_d  = widx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
      train_cnt      <= '0;
    end else if (res_fire) begin
      if (mis) mispredict_cnt <= sat_inc(mispredict_cnt);
      if (trn) train_cnt      <= sat_inc(train_cnt);
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Randomised and directed bench for perceptron_train_ctrl against a
// queue-based behavioural model of prediction recording and training.
module tb_perceptron_train_ctrl;
  import global_parameters::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 5;
  localparam int NW      = HIST_LEN + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                          clk;
  logic                          rst_n;
  logic                          pred_valid;
  logic                          pred_ready;
  logic [IDX_WIDTH-1:0]          pred_idx;
  logic signed [Y_OUT_WIDTH-1:0] pred_y;
  logic [HIST_LEN-1:0]           pred_ghr;
  logic                          res_valid;
  logic                          res_ready;
  logic                          res_taken;
  logic                          flush;
  logic                          upd_valid;
  logic                          upd_ready;
  logic [IDX_WIDTH-1:0]          upd_idx;
  logic [WIDX_WIDTH-1:0]         upd_widx;
  logic                          upd_inc;
  logic                          busy;
  logic [CNT_W-1:0]              mispredict_cnt;
  logic [CNT_W-1:0]              train_cnt;

  perceptron_train_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_idx       (pred_idx),
    .pred_y         (pred_y),
    .pred_ghr       (pred_ghr),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_taken      (res_taken),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_idx        (upd_idx),
    .upd_widx       (upd_widx),
    .upd_inc        (upd_inc),
    .busy           (busy),
    .mispredict_cnt (mispredict_cnt),
    .train_cnt      (train_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: pending predictions plus the current training episode.
  typedef struct {
    int                  idx;
    int                  y;
    logic [HIST_LEN-1:0] ghr;
  } ent_t;

  ent_t                mq[$];
  bit                  m_train;
  int                  m_k;
  int                  m_idx;
  logic [HIST_LEN-1:0] m_ghr;
  bit                  m_taken;
  int                  m_mis_cnt;
  int                  m_trn_cnt;

  // DUT-observed record of accepted updates in the current episode.
  int                  obs_acc;
  logic [NW-1:0]       obs_inc;
  int                  obs_idx;

  task automatic model_reset();
    mq.delete();
    m_train   = 0;
    m_k       = 0;
    m_mis_cnt = 0;
    m_trn_cnt = 0;
  endtask

  // Perceptron rule: weight k moves toward t*x_k, with x_0 = +1 and x_k = +/-1 from history.
  function automatic bit model_inc(input int k);
    int xk;
    int t;
    xk = (k == 0) ? 1 : (m_ghr[k-1] ? 1 : -1);
    t  = m_taken ? 1 : -1;
    return (t * xk) > 0;
  endfunction

  task automatic model_update();
    int   sz;
    ent_t e;
    int   a;
    bit   mis;
    bit   trn;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      m_train = 0;
    end else begin
      if (m_train) begin
        if (upd_ready) begin
          m_k++;
          if (m_k == NW) m_train = 0;
        end
      end else if (res_valid && sz != 0) begin
        e   = mq.pop_front();
        mis = ((e.y >= 0) != res_taken);
        a   = (e.y < 0) ? -e.y : e.y;
        trn = mis || (a <= THETA);
        if (mis && m_mis_cnt < CNT_MAX) m_mis_cnt++;
        if (trn) begin
          if (m_trn_cnt < CNT_MAX) m_trn_cnt++;
          m_train = 1;
          m_k     = 0;
          m_idx   = e.idx;
          m_ghr   = e.ghr;
          m_taken = res_taken;
        end
      end
      if (pred_valid && sz < DEPTH) begin
        e.idx = int'(pred_idx);
        e.y   = int'(pred_y);
        e.ghr = pred_ghr;
        mq.push_back(e);
      end
    end
  endtask

  // One clock: inputs already set at the falling edge; check, clock, update model.
  task automatic step();
    #1;
    check_val("pred_ready", pred_ready, mq.size() < DEPTH);
    check_val("res_ready", res_ready, !m_train && mq.size() != 0 && !flush);
    check_val("upd_valid", upd_valid, m_train);
    check_val("busy", busy, m_train);
    check_val("mispredict_cnt", mispredict_cnt, m_mis_cnt);
    check_val("train_cnt", train_cnt, m_trn_cnt);
    if (m_train) begin
      check_val("upd_idx", upd_idx, m_idx);
      check_val("upd_widx", upd_widx, m_k);
      check_val("upd_inc", upd_inc, model_inc(m_k));
    end
    if (upd_valid && upd_ready && !flush) begin
      if (int'(upd_widx) < NW) obs_inc[upd_widx] = upd_inc;
      obs_acc++;
      obs_idx = int'(upd_idx);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush      = 1'b0;
    upd_ready  = 1'b1;
  endtask

  task automatic obs_clear();
    obs_acc = 0;
    obs_inc = '0;
    obs_idx = -1;
  endtask

  task automatic push(input int y, input int idx, input logic [HIST_LEN-1:0] ghr);
    pred_valid = 1'b1;
    pred_y     = y[Y_OUT_WIDTH-1:0];
    pred_idx   = idx[IDX_WIDTH-1:0];
    pred_ghr   = ghr;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input bit taken);
    bit rdy;
    int guard;
    guard     = 0;
    res_valid = 1'b1;
    res_taken = taken;
    forever begin
      rdy = !m_train && mq.size() != 0 && !flush;
      step();
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        check_val("resolve_timeout", 1, 0);
        break;
      end
    end
    res_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,1,..., 2: random ready.
  task automatic finish_episode(input int mode);
    int guard;
    guard = 0;
    while (m_train && guard < 400) begin
      case (mode)
        0:       upd_ready = 1'b1;
        1:       upd_ready = (guard % 2 == 0);
        default: upd_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      guard++;
    end
    if (m_train) check_val("episode_timeout", 1, 0);
    upd_ready = 1'b1;
  endtask

  initial begin
    int y;
    int guard;

    idle_in();
    rst_n    = 1'b0;
    pred_idx = '0;
    pred_y   = '0;
    pred_ghr = '0;
    model_reset();
    obs_clear();
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_pred_ready", pred_ready, 1);
    check_val("rst_res_ready", res_ready, 0);
    check_val("rst_upd_valid", upd_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_upd_idx", upd_idx, 0);
    check_val("rst_upd_widx", upd_widx, 0);
    check_val("rst_upd_inc", upd_inc, 0);
    check_val("rst_mis_cnt", mispredict_cnt, 0);
    check_val("rst_trn_cnt", train_cnt, 0);
    rst_n = 1'b1;
    step();

    // Mispredict with a large margin
    obs_clear();
    push(100, 'h55, 12'h001);
    resolve(1'b0);
    finish_episode(0);
    check_val("t1_accepts", obs_acc, 13);
    check_val("t1_inc_pattern", obs_inc, 13'h1FFC);
    check_val("t1_idx", obs_idx, 'h55);
    check_val("t1_mis_cnt", mispredict_cnt, 1);
    check_val("t1_trn_cnt", train_cnt, 1);

    // Correct and confident, then correct but at the threshold
    push(38, 1, 12'($urandom));
    push(5, 2, 12'($urandom));
    resolve(1'b1);
    check_val("t2_res_ready_back", res_ready, 1);
    check_val("t2_no_train", busy, 0);
    check_val("t2_trn_cnt", train_cnt, 1);
    resolve(1'b1);
    finish_episode(2);
    obs_clear();
    push(37, 3, 12'($urandom));
    resolve(1'b1);
    check_val("t2_theta_train", busy, 1);
    check_val("t2_theta_inc0", upd_inc, 1);
    finish_episode(0);
    check_val("t2_theta_accepts", obs_acc, 13);

    // Most negative y
    push(-(1 << (Y_OUT_WIDTH - 1)), 4, 12'($urandom));
    resolve(1'b0);
    check_val("t3_min_no_train", busy, 0);
    push(-(1 << (Y_OUT_WIDTH - 1)), 5, 12'($urandom));
    resolve(1'b1);
    check_val("t3_min_train", busy, 1);
    finish_episode(0);

    // Full queue and backpressured episode
    for (int i = 0; i < 4; i++) push(100, 10 + i, 12'($urandom));
    check_val("t4_full", pred_ready, 0);
    push(100, 99, 12'($urandom));
    obs_clear();
    resolve(1'b0);
    finish_episode(1);
    check_val("t4_accepts", obs_acc, 13);
    check_val("t4_idx", obs_idx, 10);
    for (int i = 0; i < 3; i++) begin
      resolve(1'($urandom_range(0, 1)));
      finish_episode(2);
    end
    check_val("t4_drained", res_ready, 0);

    // Flush mid-episode
    push(100, 20, 12'($urandom));
    push(50, 21, 12'($urandom));
    resolve(1'b0);
    guard = 0;
    while (m_k != 5 && guard < 50) begin
      step();
      guard++;
    end
    check_val("t5_widx5", upd_widx, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("t5_upd_valid", upd_valid, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_pred_ready", pred_ready, 1);
    check_val("t5_res_ready", res_ready, 0);
    step();

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      pred_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       y = int'($urandom_range(0, 120)) - 60;
        1:       y = int'($urandom_range(0, 4095)) - 2048;
        2:       y = -2048;
        default: y = int'($urandom_range(0, 400)) - 200;
      endcase
      pred_y     = y[Y_OUT_WIDTH-1:0];
      pred_idx   = 7'($urandom);
      pred_ghr   = 12'($urandom);
      res_valid  = 1'($urandom_range(0, 1));
      res_taken  = 1'($urandom_range(0, 1));
      upd_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Asynchronous reset mid-episode
    push(100, 30, 12'($urandom));
    resolve(1'b0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_upd_valid", upd_valid, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_pred_ready", pred_ready, 1);
    check_val("t6_res_ready", res_ready, 0);
    check_val("t6_mis_cnt", mispredict_cnt, 0);
    check_val("t6_trn_cnt", train_cnt, 0);
    check_val("t6_upd_inc", upd_inc, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      push(100, i, 12'($urandom));
      resolve(1'b0);
      finish_episode(0);
    end
    check_val("t7_mis_sat", mispredict_cnt, CNT_MAX);
    check_val("t7_trn_sat", train_cnt, CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
